// File: rtl/stepper_move_controller.sv
// Counted, abortable stepper move sequencer driving STEP/DIR/ENABLE with programmable timing.
// Define STEPPER_RAMP_EN to add a symmetric linear speed ramp at the start and end of each move.
module stepper_move_controller #(
  parameter int unsigned PERIOD_MIN = 20000,
  parameter int unsigned PERIOD_MAX = 100000,
  parameter int unsigned RAMP_DEC   = 500,
  parameter int unsigned PULSE_W    = 100,
  parameter int unsigned DIR_SETUP  = 50
) (
  input  logic        clk,
  input  logic        reset_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_steps,
  input  logic        cmd_dir,
  input  logic        abort,
  output logic        step,
  output logic        dir,
  output logic        motor_en,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [15:0] steps_left
);

  localparam logic [31:0] P_MIN = 32'(PERIOD_MIN);
  localparam logic [31:0] PW    = 32'(PULSE_W);
  localparam logic [31:0] DS    = 32'(DIR_SETUP);

  if (PERIOD_MIN <= PULSE_W || PERIOD_MAX < PERIOD_MIN || DIR_SETUP < 1 ||
      PULSE_W < 1 || RAMP_DEC < 1) begin : g_bad_cfg
    $error("stepper_move_controller: inconsistent timing parameters");
  end

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_e;

  state_e      state_q;
  logic [31:0] cnt_q;
  logic [15:0] steps_q;
  logic        step_q, dir_q, busy_q, done_q, aborted_q, abort_pend_q;
  logic [31:0] period_cur;

`ifdef STEPPER_RAMP_EN
  localparam logic [31:0] P_MAX = 32'(PERIOD_MAX);
  localparam logic [31:0] DEC   = 32'(RAMP_DEC);

  logic [31:0] period_q, period_next;
  logic [15:0] accel_q;
  logic        accel_inc;

  // Decelerate once the steps remaining after this rise fit inside the ramp-up length.
  always_comb begin
    period_next = period_q;
    accel_inc   = 1'b0;
    if (16'(steps_q - 16'd1) <= accel_q) begin
      period_next = (P_MAX - period_q <= DEC) ? P_MAX : period_q + DEC;
    end else if (period_q > P_MIN) begin
      period_next = (period_q - P_MIN <= DEC) ? P_MIN : period_q - DEC;
      accel_inc   = 1'b1;
    end
  end

  assign period_cur = period_q;
`else
  assign period_cur = P_MIN;
`endif

  // NOTE: every register here is updated with <= so all of them see pre-edge values.
  always_ff @(posedge clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      steps_q      <= '0;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
`ifdef STEPPER_RAMP_EN
      period_q     <= '0;
      accel_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q      <= SETUP;
            dir_q        <= cmd_dir;
            steps_q      <= cmd_steps;
            busy_q       <= 1'b1;
            cnt_q        <= DS - 32'd1;
            abort_pend_q <= 1'b0;
`ifdef STEPPER_RAMP_EN
            period_q     <= P_MAX;
            accel_q      <= '0;
`endif
          end
        end
        SETUP: begin
          if (abort || steps_q == '0) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            aborted_q <= abort;
            busy_q    <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= HIGH;
            step_q  <= 1'b1;
            steps_q <= steps_q - 16'd1;
            cnt_q   <= PW - 32'd1;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        HIGH: begin
          // An abort seen mid-pulse is remembered; the pulse always completes.
          if (cnt_q == '0) begin
            step_q <= 1'b0;
            if (abort || abort_pend_q) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              aborted_q <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              state_q <= LOW;
              cnt_q   <= period_cur - PW - 32'd1;
            end
          end else begin
            cnt_q <= cnt_q - 32'd1;
            if (abort) abort_pend_q <= 1'b1;
          end
        end
        LOW: begin
          if (abort || (cnt_q == '0 && steps_q == '0)) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            aborted_q <= abort;
            busy_q    <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= HIGH;
            step_q  <= 1'b1;
            steps_q <= steps_q - 16'd1;
            cnt_q   <= PW - 32'd1;
`ifdef STEPPER_RAMP_EN
            period_q <= period_next;
            accel_q  <= 16'(accel_q + {15'd0, accel_inc});
`endif
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          done_q    <= 1'b0;
          aborted_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = reset_reset_n && (state_q == IDLE);
  assign step       = step_q;
  assign dir        = dir_q;
  assign motor_en   = busy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign steps_left = steps_q;

endmodule

// File: tb/tb_stepper_move_controller.sv
// Scoreboard bench: the driver queues expected rise/done cycles, a monitor pops and compares.
module tb_stepper_move_controller;

  localparam int PULSE_W = 20;

  logic        clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic        abort = 1'b0;
  logic        step, dir, motor_en, busy, done, aborted;
  logic [15:0] steps_left;

  typedef struct {
    int          cyc;
    logic        ab;
    logic [15:0] sl;
  } exp_t;

  int   exp_rise[$];
  exp_t exp_done[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   rise_count = 0;

  stepper_move_controller #(
    .PERIOD_MIN(200), .PERIOD_MAX(300), .RAMP_DEC(50), .PULSE_W(PULSE_W), .DIR_SETUP(5)
  ) dut (
    .clk(clk), .reset_reset_n(reset_reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .abort(abort), .step(step), .dir(dir),
    .motor_en(motor_en), .busy(busy), .done(done), .aborted(aborted), .steps_left(steps_left)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, required fewer", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic step_prev = 1'b0;
    logic done_prev = 1'b0;
    int   rise_cyc  = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_reset_n) begin
        step_prev = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (done_prev) check("ready_after_done", cmd_ready, 1);
        if (step && !step_prev) begin
          rise_count++;
          rise_cyc = cyc;
          if (exp_rise.size() == 0) check("unexpected_rise_count", exp_rise.size(), 1);
          else check("rise_cycle", cyc, exp_rise.pop_front());
        end
        if (!step && step_prev) check("pulse_width", cyc - rise_cyc, PULSE_W);
        if (done) begin
          if (exp_done.size() == 0) check("unexpected_done_count", exp_done.size(), 1);
          else begin
            e = exp_done.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("done_aborted", aborted, e.ab);
            check("done_steps_left", steps_left, e.sl);
            check("done_busy", busy, 0);
            check("rises_missing", exp_rise.size(), 0);
          end
        end
        step_prev = step;
        done_prev = done;
      end
    end
  endtask

  task automatic issue(input logic [15:0] steps, input logic d, input int nr, input int ro[8],
                       input int done_off, input logic ab, input logic [15:0] sl,
                       output int t0);
    int   guard = 0;
    exp_t e;
    @(negedge clk);
    while (!cmd_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_steps = steps;
    cmd_dir   = d;
    t0        = cyc;
    for (int i = 0; i < nr; i++) exp_rise.push_back(t0 + ro[i]);
    e.cyc = t0 + done_off;
    e.ab  = ab;
    e.sl  = sl;
    exp_done.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("dir_t0p1", dir, d);
    check("busy_t0p1", busy, 1);
    check("motor_en_t0p1", motor_en, 1);
    check("ready_low_t0p1", cmd_ready, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cmd_ready && exp_done.size() == 0) && n < budget);
    check("move_complete_pending", exp_done.size(), 0);
  endtask

  initial begin
    int t0;
    int r4[8], r10[8], r2[8], r6[8];
    int d4, d10, d2, d6, ab_off;
`ifdef STEPPER_RAMP_EN
    r4  = '{6, 306, 556, 856, 0, 0, 0, 0};          d4  = 1156;
    r10 = '{6, 306, 556, 0, 0, 0, 0, 0};            d10 = 576;  ab_off = 560;
    r2  = '{6, 306, 0, 0, 0, 0, 0, 0};              d2  = 606;
    r6  = '{6, 306, 556, 756, 1006, 1306, 0, 0};    d6  = 1606;
`else
    r4  = '{6, 206, 406, 606, 0, 0, 0, 0};          d4  = 806;
    r10 = '{6, 206, 406, 0, 0, 0, 0, 0};            d10 = 426;  ab_off = 410;
    r2  = '{6, 206, 0, 0, 0, 0, 0, 0};              d2  = 406;
    r6  = '{0, 0, 0, 0, 0, 0, 0, 0};                d6  = 0;
`endif
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_outputs", {step, dir, motor_en, busy, done, aborted}, 0);
    check("rst_steps_left", steps_left, 0);
    #2 reset_reset_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_outputs", {step, dir, motor_en, busy, done, aborted}, 0);
    repeat (10000) @(negedge clk);
    check("idle_no_steps", rise_count, 0);

    issue(16'd4, 1'b1, 4, r4, d4, 1'b0, 16'd0, t0);
    wait_idle(3000);

    issue(16'd0, 1'b0, 0, r4, 2, 1'b0, 16'd0, t0);
    check("zero_dir_low", dir, 0);
    wait_idle(100);

    issue(16'd10, 1'b1, 3, r10, d10, 1'b1, 16'd7, t0);
    while (cyc < t0 + ab_off) @(negedge clk);
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    wait_idle(3000);

    issue(16'd4, 1'b0, 4, r4, d4, 1'b0, 16'd0, t0);
    while (cyc < t0 + 10) @(negedge clk);
    #2 reset_reset_n = 1'b0;
    #1;
    check("async_rst_step", step, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_motor_en", motor_en, 0);
    exp_rise.delete();
    exp_done.delete();
    repeat (3) @(negedge clk);
    #2 reset_reset_n = 1'b1;
    #1;
    check("post_rst_ready", cmd_ready, 1);
    issue(16'd2, 1'b1, 2, r2, d2, 1'b0, 16'd0, t0);
    wait_idle(3000);

`ifdef STEPPER_RAMP_EN
    issue(16'd6, 1'b1, 6, r6, d6, 1'b0, 16'd0, t0);
    wait_idle(4000);
`else
    if (d6 != 0 || r6[0] != 0) $display("note: ramp table unused");
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stepper_move_controller.md
# stepper_move_controller

Sequences one stepper-motor move: accepts a step-count/direction command over a valid/ready handshake and emits STEP/DIR/ENABLE to the stepper driver with programmable pulse width, direction setup time and step period. It replaces free-running divided-clock stepping in the forklift drive path with counted, abortable moves, and optionally applies a linear speed ramp at the start and end of each move.

## Interface
- PERIOD_MIN, 20000: fastest step period in clk cycles, rising edge to rising edge; must be greater than PULSE_W.
- PERIOD_MAX, 100000: start/stop step period in ramp mode; must be at least PERIOD_MIN.
- RAMP_DEC, 500: period change in cycles per step in ramp mode.
- PULSE_W, 100: STEP high time in cycles.
- DIR_SETUP, 50: cycles from DIR valid to the first STEP rise; minimum 1.
- clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_steps  in  16  number of steps to issue.
- cmd_dir  in  1  1 = forward.
- abort  in  1  level; stops the move early.
- step  out  1  driver STEP.
- dir  out  1  driver DIR, held between moves.
- motor_en  out  1  driver enable, high while busy.
- busy  out  1  move in progress.
- done  out  1  one-cycle pulse at end of move.
- aborted  out  1  valid with done: the move ended by abort.
- steps_left  out  16  steps not yet issued.

## Operation
- States: IDLE, SETUP, HIGH, LOW, DONE.
- Reset value of every output is 0. The exception is cmd_ready, which is 1 once reset is deasserted, because the block is in IDLE.
- IDLE: a command is accepted on a cycle with cmd_valid && cmd_ready. The block then latches dir, steps_left and the period, and goes to SETUP.
- SETUP: waits DIR_SETUP cycles, then goes to HIGH. If steps_left is 0, it goes directly to DONE after 1 cycle.
- HIGH: step=1 for PULSE_W cycles. steps_left decrements on entry to HIGH.
- LOW: step=0 for (period − PULSE_W) cycles. When LOW ends, go to HIGH if steps_left>0, else to DONE.
- DONE: lasts 1 cycle. done=1 and busy=0 in this cycle. Then go to IDLE.
- abort: sampled in SETUP, HIGH and LOW.
  - In SETUP or LOW, abort goes to DONE on the next cycle.
  - In HIGH, the pulse finishes its full PULSE_W, then goes to DONE.
  - aborted=1 in the DONE cycle; steps_left holds the unissued count.
- abort has no effect in IDLE or DONE. abort and cmd_valid in the same IDLE cycle: the command is accepted, and abort acts from SETUP.
- Counters: the period counter is 32-bit and the step counter is 16-bit. Counters never wrap: steps_left saturates at 0.

## Timing
- Command accepted at T0:
  - dir, motor_en and busy are valid at T0+1.
  - First step rise is at T0+1+DIR_SETUP.
- Rising-edge-to-rising-edge spacing equals the current period exactly.
- With the last step rising at Tn: done pulses at Tn+period, and cmd_ready=1 at Tn+period+1.
- cmd_steps=0: done at T0+2.
- Reset asserted mid-move: step, motor_en and busy go to 0 immediately (asynchronously). The state returns to IDLE and the move is discarded.

## Configuration
- STEPPER_RAMP_EN defined:
  - First-step period is PERIOD_MAX.
  - Each later step's period is reduced by RAMP_DEC, floored at PERIOD_MIN. The number of accelerating steps is counted.
  - Once steps_left ≤ the accelerating count, each period is increased by RAMP_DEC, capped at PERIOD_MAX.
  - The ramp is symmetric, and an abort does not ramp down.
- STEPPER_RAMP_EN undefined: every period is PERIOD_MIN, and no ramp logic is present.

## Test plan
- Reset is deasserted with cmd_valid=0 → all outputs 0, cmd_ready=1, and no step edges for 10000 cycles.
- No ramp; PERIOD_MIN=200, PULSE_W=20, DIR_SETUP=5; cmd_steps=4, dir=1 → dir=1 at T0+1; 4 pulses, each 20 cycles high, with rises at T0+6, T0+206, T0+406 and T0+606; done at T0+806; steps_left=0.
- cmd_steps=0 → no step pulse; done at T0+2; aborted=0.
- abort raised in the 3rd pulse's HIGH phase of a 10-step move → the pulse stays high for the full 20 cycles, then done with aborted=1 and steps_left=7.
- Reset asserted at a mid-move HIGH phase → step=0 in the same cycle; after release, a new 2-step command executes normally.
- STEPPER_RAMP_EN defined; PERIOD_MAX=300, PERIOD_MIN=200, RAMP_DEC=50; 6 steps → rise-to-rise spacings of 300, 250, 200, 250, 300; done 300 cycles after the 6th rise.
